// File: rtl/piece_position_reg.sv
// Purpose : coordinate register for the falling piece, with spawn, candidate commit and lock sequencing.
// Latency : every response is registered and appears one CLK after the triggering input edge.
// Backpr. : candidates are sampled only while cand_ready (== active) is high; nothing is queued.
//
// Ports:
//   CLK, reset              clock (rising edge) and synchronous active-low reset
//   spawn, spawn_x/_y       load a new piece while the board is empty
//   cand_valid, cand_x/_y   candidate move/rotate position from the move generator
//   cand_ok                 collision checker verdict for the presented candidate
//   placed                  piece has landed; start the one-cycle lock sequence
//   cur_x, cur_y            current packed coordinates (held after lock; gate with active)
//   active, cand_ready      piece in play; candidates accepted only while high
//   accepted, rejected      one-cycle verdict pulses for a sampled candidate
//   lock_pulse              high during the single LOCK cycle
//   move_count              accepted moves since the last spawn, saturating
module piece_position_reg #(
   parameter int CELLS = 4,
   parameter int X_W   = 3,
   parameter int Y_W   = 4,
   parameter int X_MAX = 7,
   parameter int Y_MAX = 15,
   parameter int CNT_W = 8
) (
   input  logic                   CLK,
   input  logic                   reset,
   input  logic                   spawn,
   input  logic [CELLS*X_W-1:0]   spawn_x,
   input  logic [CELLS*Y_W-1:0]   spawn_y,
   input  logic                   cand_valid,
   input  logic [CELLS*X_W-1:0]   cand_x,
   input  logic [CELLS*Y_W-1:0]   cand_y,
   input  logic                   cand_ok,
   input  logic                   placed,
   output logic [CELLS*X_W-1:0]   cur_x,
   output logic [CELLS*Y_W-1:0]   cur_y,
   output logic                   active,
   output logic                   cand_ready,
   output logic                   accepted,
   output logic                   rejected,
   output logic                   lock_pulse,
   output logic [CNT_W-1:0]       move_count
);

   typedef enum logic [1:0] {
      S_EMPTY  = 2'd0,
      S_ACTIVE = 2'd1,
      S_LOCK   = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

   state_t state;
   logic   in_bounds;
   logic   cand_take;

   // Per-cell unsigned bounds test. Compared as int so that a limit equal to
   // the field maximum does not turn into a degenerate constant comparison.
   always_comb begin
      in_bounds = 1'b1;
      for (int i = 0; i < CELLS; i++) begin
         if (int'(cand_x[i*X_W +: X_W]) > X_MAX)
            in_bounds = 1'b0;
         if (int'(cand_y[i*Y_W +: Y_W]) > Y_MAX)
            in_bounds = 1'b0;
      end
   end

   // Commit only if the checker is happy and every cell lies on the board.
   assign cand_take  = cand_ok & in_bounds;

   assign cand_ready = active;

   always_ff @(posedge CLK) begin
      if (!reset) begin
         state      <= S_EMPTY;
         cur_x      <= '0;
         cur_y      <= '0;
         move_count <= '0;
         active     <= 1'b0;
         accepted   <= 1'b0;
         rejected   <= 1'b0;
         lock_pulse <= 1'b0;
      end else begin
         // Pulses default low so each is high for exactly one cycle.
         accepted   <= 1'b0;
         rejected   <= 1'b0;
         lock_pulse <= 1'b0;

         case (state)
            S_EMPTY: begin
               if (spawn) begin
                  cur_x      <= spawn_x;
                  cur_y      <= spawn_y;
                  move_count <= '0;
                  state      <= S_ACTIVE;
                  active     <= 1'b1;
               end
            end

            S_ACTIVE: begin
               if (placed) begin
                  // Landing wins over a same-cycle candidate; it is dropped silently.
                  state      <= S_LOCK;
                  active     <= 1'b0;
                  lock_pulse <= 1'b1;
               end else if (cand_valid) begin
                  if (cand_take) begin
                     cur_x    <= cand_x;
                     cur_y    <= cand_y;
                     accepted <= 1'b1;
                     if (move_count != CNT_SAT)
                        move_count <= move_count + CNT_ONE;
                  end else begin
                     rejected <= 1'b1;
                  end
               end
            end

            S_LOCK: begin
               // Single lock cycle; a spawn seen here is not remembered.
               state  <= S_EMPTY;
               active <= 1'b0;
            end

            default: begin
               state  <= S_EMPTY;
               active <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_piece_position_reg.sv
module tb_piece_position_reg;

   localparam int CELLS = 4;
   localparam int X_W   = 3;
   localparam int Y_W   = 4;

   logic                 CLK = 1'b0;
   logic                 reset;
   logic                 spawn;
   logic [CELLS*X_W-1:0] spawn_x;
   logic [CELLS*Y_W-1:0] spawn_y;
   logic                 cand_valid;
   logic [CELLS*X_W-1:0] cand_x;
   logic [CELLS*Y_W-1:0] cand_y;
   logic                 cand_ok;
   logic                 placed;

   // Instance 0: default parameters. Instance 1: Y_MAX=14, CNT_W=2.
   logic [CELLS*X_W-1:0] cur_x0, cur_x1;
   logic [CELLS*Y_W-1:0] cur_y0, cur_y1;
   logic                 active0, active1, ready0, ready1;
   logic                 acc0, acc1, rej0, rej1, lk0, lk1;
   logic [7:0]           mc0;
   logic [1:0]           mc1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 CLK = ~CLK;

   piece_position_reg dut0 (
      .CLK(CLK), .reset(reset), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y), .cand_ok(cand_ok),
      .placed(placed), .cur_x(cur_x0), .cur_y(cur_y0), .active(active0),
      .cand_ready(ready0), .accepted(acc0), .rejected(rej0), .lock_pulse(lk0),
      .move_count(mc0)
   );

   piece_position_reg #(.Y_MAX(14), .CNT_W(2)) dut1 (
      .CLK(CLK), .reset(reset), .spawn(spawn), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .cand_valid(cand_valid), .cand_x(cand_x), .cand_y(cand_y), .cand_ok(cand_ok),
      .placed(placed), .cur_x(cur_x1), .cur_y(cur_y1), .active(active1),
      .cand_ready(ready1), .accepted(acc1), .rejected(rej1), .lock_pulse(lk1),
      .move_count(mc1)
   );

   // ---------------- reference model ----------------
   // Piece described as plain integer cell lists plus "in play" / "locking" flags.
   int m_y_max [2] = '{15, 14};
   int m_cnt_max[2] = '{255, 3};
   int m_x   [2][CELLS];
   int m_y   [2][CELLS];
   int m_cnt [2];
   bit m_play[2];
   bit m_lock[2];
   bit m_acc [2];
   bit m_rej [2];

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         bit good;
         m_acc[k] = 1'b0;
         m_rej[k] = 1'b0;
         if (!reset) begin
            m_play[k] = 1'b0;
            m_lock[k] = 1'b0;
            m_cnt[k]  = 0;
            for (int c = 0; c < CELLS; c++) begin
               m_x[k][c] = 0;
               m_y[k][c] = 0;
            end
         end else if (m_lock[k]) begin
            m_lock[k] = 1'b0;
         end else if (!m_play[k]) begin
            if (spawn) begin
               for (int c = 0; c < CELLS; c++) begin
                  m_x[k][c] = int'(spawn_x[c*X_W +: X_W]);
                  m_y[k][c] = int'(spawn_y[c*Y_W +: Y_W]);
               end
               m_cnt[k]  = 0;
               m_play[k] = 1'b1;
            end
         end else if (placed) begin
            m_play[k] = 1'b0;
            m_lock[k] = 1'b1;
         end else if (cand_valid) begin
            good = cand_ok;
            for (int c = 0; c < CELLS; c++) begin
               if (int'(cand_x[c*X_W +: X_W]) > 7) good = 1'b0;
               if (int'(cand_y[c*Y_W +: Y_W]) > m_y_max[k]) good = 1'b0;
            end
            if (good) begin
               for (int c = 0; c < CELLS; c++) begin
                  m_x[k][c] = int'(cand_x[c*X_W +: X_W]);
                  m_y[k][c] = int'(cand_y[c*Y_W +: Y_W]);
               end
               m_acc[k] = 1'b1;
               m_cnt[k] = (m_cnt[k] + 1 > m_cnt_max[k]) ? m_cnt_max[k] : m_cnt[k] + 1;
            end else begin
               m_rej[k] = 1'b1;
            end
         end
      end
   endtask

   function automatic logic [31:0] pack_x(int k);
      logic [31:0] r = '0;
      for (int c = 0; c < CELLS; c++) r = r | (32'(m_x[k][c]) << (c*X_W));
      return r;
   endfunction

   function automatic logic [31:0] pack_y(int k);
      logic [31:0] r = '0;
      for (int c = 0; c < CELLS; c++) r = r | (32'(m_y[k][c]) << (c*Y_W));
      return r;
   endfunction

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_all();
      check("d0_cur_x",  32'(cur_x0),  pack_x(0));
      check("d0_cur_y",  32'(cur_y0),  pack_y(0));
      check("d0_active", 32'(active0), 32'(m_play[0]));
      check("d0_ready",  32'(ready0),  32'(m_play[0]));
      check("d0_acc",    32'(acc0),    32'(m_acc[0]));
      check("d0_rej",    32'(rej0),    32'(m_rej[0]));
      check("d0_lock",   32'(lk0),     32'(m_lock[0]));
      check("d0_cnt",    32'(mc0),     32'(m_cnt[0]));
      check("d1_cur_x",  32'(cur_x1),  pack_x(1));
      check("d1_cur_y",  32'(cur_y1),  pack_y(1));
      check("d1_active", 32'(active1), 32'(m_play[1]));
      check("d1_ready",  32'(ready1),  32'(m_play[1]));
      check("d1_acc",    32'(acc1),    32'(m_acc[1]));
      check("d1_rej",    32'(rej1),    32'(m_rej[1]));
      check("d1_lock",   32'(lk1),     32'(m_lock[1]));
      check("d1_cnt",    32'(mc1),     32'(m_cnt[1]));
   endtask

   // Drive one cycle of inputs, advance one edge, update the model, compare.
   task automatic apply(input bit rst_n, input bit sp, input bit cv, input bit ok, input bit pl,
                        input logic [CELLS*X_W-1:0] sx, input logic [CELLS*Y_W-1:0] sy,
                        input logic [CELLS*X_W-1:0] cx, input logic [CELLS*Y_W-1:0] cy);
      reset      = rst_n;
      spawn      = sp;
      cand_valid = cv;
      cand_ok    = ok;
      placed     = pl;
      spawn_x    = sx;
      spawn_y    = sy;
      cand_x     = cx;
      cand_y     = cy;
      @(posedge CLK);
      model_step();
      #1;
      check_all();
   endtask

   int exp_seq[5] = '{1, 2, 3, 3, 3};

   initial begin
      // Reset with every other input asserted.
      apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 12'hFFF, 16'hFFFF, 12'hABC, 16'h1234);
      check("rst_active", 32'(active0), 32'd0);
      check("rst_cnt",    32'(mc0),     32'd0);

      // Spawn with x cells 1,2,3,4 and y cells 0,1,2,3.
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h8D1, 16'h3210, 12'h000, 16'h0000);
      check("spawn_cur_x",  32'(cur_x0),  32'h8D1);
      check("spawn_active", 32'(active0), 32'd1);

      // Every x +1 (cells 2,3,4,5), accepted.
      apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 12'hB1A, 16'h3210);
      check("move_cur_x", 32'(cur_x0), 32'hB1A);
      check("move_cnt",   32'(mc0),    32'd1);
      // Same shape back with cand_ok low: rejected, cur and count unchanged.
      apply(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 12'h000, 16'h0000, 12'h8D1, 16'h3210);
      check("rej_pulse", 32'(rej0),   32'd1);
      check("rej_cur_x", 32'(cur_x0), 32'hB1A);
      // One cell at x=7 is still on the board.
      apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 12'hF1A, 16'h3210);
      check("xmax_acc", 32'(acc0), 32'd1);
      // One cell at y=15: inside default board, outside Y_MAX=14.
      apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 12'hF1A, 16'hF210);
      check("ymax15_acc", 32'(acc0), 32'd1);
      check("ymax14_rej", 32'(rej1), 32'd1);

      // Land with a good candidate on the same cycle.
      apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 16'h0000, 12'h249, 16'h1111);
      check("land_no_acc", 32'(acc0), 32'd0);
      check("land_lock",   32'(lk0),  32'd1);
      // Spawn during LOCK is dropped.
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h123, 16'h4567, 12'h000, 16'h0000);
      check("lock_spawn_ign", 32'(active0), 32'd0);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000);
      check("still_empty", 32'(active0), 32'd0);

      // Fresh spawn, then five accepted moves to saturate the 2-bit counter.
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000);
      for (int i = 0; i < 5; i++) begin
         apply(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000,
               12'($urandom_range(0, 4095)), 16'h4321 + 16'(i));
         check("sat_seq", 32'(mc1), 32'(exp_seq[i]));
      end
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 12'h000, 16'h0000, 12'h000, 16'h0000);
      apply(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000, 16'h0000, 12'h000, 16'h0000);
      apply(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 12'h555, 16'h6666, 12'h000, 16'h0000);
      check("respawn_cnt", 32'(mc1), 32'd0);

      // Reset on the same edge as a good candidate.
      apply(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 12'h000, 16'h0000, 12'h777, 16'h1234);
      check("rst_mid_acc",   32'(acc0),   32'd0);
      check("rst_mid_cur_x", 32'(cur_x0), 32'd0);

      // Randomised traffic.
      for (int n = 0; n < 3000; n++) begin
         apply(($urandom_range(0, 99) >= 2),
               ($urandom_range(0, 99) < 30),
               ($urandom_range(0, 99) < 60),
               ($urandom_range(0, 99) < 70),
               ($urandom_range(0, 99) < 8),
               12'($urandom), 16'($urandom), 12'($urandom), 16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
